// File: rtl/adc_menu_fsm.sv
// rtl/adc_menu_fsm.sv - pushbutton menu selecting ADC source and display format
module adc_menu_fsm #(
  parameter int         DEBOUNCE_CYCLES = 1_000_000,
  parameter int         TIMEOUT_CYCLES  = 500_000_000,
  parameter logic [1:0] RESET_SOURCE    = 2'b01,
  parameter logic [1:0] RESET_FORMAT    = 2'b01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_enter,
  input  logic        btn_next,
  input  logic        btn_prev,
  output logic [1:0]  FSM_outputs,
  output logic [1:0]  bin_bcd_select,
  output logic        menu_active,
  output logic [15:0] menu_display
);

  localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DCW-1:0] DEB_LAST = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_SEL_SOURCE = 2'd1,
    ST_SEL_FORMAT = 2'd2
  } state_e;

  // bit 0 = enter, bit 1 = next, bit 2 = prev
  logic [2:0] btn_raw;
  logic [2:0] sync1_q, sync2_q, deb_last_q, press_q;
  logic [2:0] deb_w;

  assign btn_raw = {btn_prev, btn_next, btn_enter};

  for (genvar i = 0; i < 3; i++) begin : g_debounce
    logic [DCW-1:0] cnt_q;
    logic           deb_q;

    // Accept a new level only after it differed from the debounced level for DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q <= '0;
        deb_q <= 1'b0;
      end else if (sync2_q[i] != deb_q) begin
        if (cnt_q == DEB_LAST) begin
          deb_q <= sync2_q[i];
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end

    assign deb_w[i] = deb_q;
  end

  // Synchronize raw buttons and register a one-cycle pulse on each debounced rising edge
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_last_q <= '0;
      press_q    <= '0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      deb_last_q <= deb_w;
      press_q    <= deb_w & ~deb_last_q;
    end
  end

  // Enter dominates; next and prev cancel each other
  logic enter_p, next_p, prev_p;
  assign enter_p = press_q[0];
  assign next_p  = press_q[1] & ~press_q[0] & ~press_q[2];
  assign prev_p  = press_q[2] & ~press_q[0] & ~press_q[1];

  state_e         state_q, state_d;
  logic [1:0]     cand_src_q, cand_src_d;
  logic [1:0]     cand_fmt_q, cand_fmt_d;
  logic [1:0]     src_q, src_d;
  logic [1:0]     fmt_q, fmt_d;
  logic [TCW-1:0] tmo_q, tmo_d;
  logic           active_q;
  logic [15:0]    disp_q;

  // Next-state, candidate browsing, idle timeout and atomic commit
  always_comb begin
    state_d    = state_q;
    cand_src_d = cand_src_q;
    cand_fmt_d = cand_fmt_q;
    src_d      = src_q;
    fmt_d      = fmt_q;
    tmo_d      = '0;
    case (state_q)
      ST_RUN: begin
        if (enter_p) begin
          state_d    = ST_SEL_SOURCE;
          cand_src_d = src_q;
          cand_fmt_d = fmt_q;
        end
      end
      ST_SEL_SOURCE: begin
        if (enter_p) begin
          state_d = ST_SEL_FORMAT;
        end else if (next_p) begin
          cand_src_d = cand_src_q + 2'd1;
        end else if (prev_p) begin
          cand_src_d = cand_src_q - 2'd1;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_RUN;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_SEL_FORMAT: begin
        if (enter_p) begin
          state_d = ST_RUN;
          src_d   = cand_src_q;
          fmt_d   = cand_fmt_q;
        end else if (next_p) begin
          case (cand_fmt_q)
            2'd0:    cand_fmt_d = 2'd1;
            2'd1:    cand_fmt_d = 2'd2;
            default: cand_fmt_d = 2'd0;
          endcase
        end else if (prev_p) begin
          case (cand_fmt_q)
            2'd0:    cand_fmt_d = 2'd2;
            2'd1:    cand_fmt_d = 2'd0;
            default: cand_fmt_d = 2'd1;
          endcase
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_RUN;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State, candidates, committed selections, and registered display decode
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      cand_src_q <= '0;
      cand_fmt_q <= '0;
      src_q      <= RESET_SOURCE;
      fmt_q      <= RESET_FORMAT;
      tmo_q      <= '0;
      active_q   <= 1'b0;
      disp_q     <= '0;
    end else begin
      state_q    <= state_d;
      cand_src_q <= cand_src_d;
      cand_fmt_q <= cand_fmt_d;
      src_q      <= src_d;
      fmt_q      <= fmt_d;
      tmo_q      <= tmo_d;
      active_q   <= (state_q == ST_SEL_SOURCE) || (state_q == ST_SEL_FORMAT);
      case (state_q)
        ST_SEL_SOURCE: disp_q <= {4'h5, 8'h00, 2'b00, cand_src_q};
        ST_SEL_FORMAT: disp_q <= {4'hF, 8'h00, 2'b00, cand_fmt_q};
        default:       disp_q <= 16'h0000;
      endcase
    end
  end

  assign FSM_outputs    = src_q;
  assign bin_bcd_select = fmt_q;
  assign menu_active    = active_q;
  assign menu_display   = disp_q;

endmodule

// File: tb/tb_adc_menu_fsm.sv
// tb/tb_adc_menu_fsm.sv - directed self-checking bench for adc_menu_fsm
module tb_adc_menu_fsm;

  localparam logic [2:0] B_NONE  = 3'b000;
  localparam logic [2:0] B_ENTER = 3'b001;
  localparam logic [2:0] B_NEXT  = 3'b010;
  localparam logic [2:0] B_PREV  = 3'b100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btn_enter = 1'b0;
  logic        btn_next = 1'b0;
  logic        btn_prev = 1'b0;
  logic [1:0]  FSM_outputs;
  logic [1:0]  bin_bcd_select;
  logic        menu_active;
  logic [15:0] menu_display;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  adc_menu_fsm #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (50),
    .RESET_SOURCE   (2'b01),
    .RESET_FORMAT   (2'b01)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_enter     (btn_enter),
    .btn_next      (btn_next),
    .btn_prev      (btn_prev),
    .FSM_outputs   (FSM_outputs),
    .bin_bcd_select(bin_bcd_select),
    .menu_active   (menu_active),
    .menu_display  (menu_display)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [2:0] b);
    {btn_prev, btn_next, btn_enter} = b;
  endtask

  task automatic press(input logic [2:0] b);
    drive(b);
    step(8);
    drive(B_NONE);
    step(8);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    drive(B_NONE);
    step(3);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    step(1);
    total++; if (FSM_outputs !== 2'b01) begin bad++; $display("FAIL rst_src got=%b want=01", FSM_outputs); end
    total++; if (bin_bcd_select !== 2'b01) begin bad++; $display("FAIL rst_fmt got=%b want=01", bin_bcd_select); end
    total++; if (menu_active !== 1'b0) begin bad++; $display("FAIL rst_active got=%b want=0", menu_active); end
    total++; if (menu_display !== 16'h0000) begin bad++; $display("FAIL rst_disp got=%h want=0000", menu_display); end
  endtask

  task automatic test_browse_commit;
    bit mixed;
    do_reset();
    press(B_ENTER);
    total++; if (menu_display !== 16'h5001) begin bad++; $display("FAIL br_open got=%h want=5001", menu_display); end
    total++; if (menu_active !== 1'b1) begin bad++; $display("FAIL br_active got=%b want=1", menu_active); end
    press(B_NEXT);
    press(B_NEXT);
    total++; if (menu_display !== 16'h5003) begin bad++; $display("FAIL br_src3 got=%h want=5003", menu_display); end
    press(B_ENTER);
    total++; if (menu_display !== 16'hF001) begin bad++; $display("FAIL br_fmt_open got=%h want=F001", menu_display); end
    press(B_PREV);
    total++; if (menu_display !== 16'hF000) begin bad++; $display("FAIL br_fmt0 got=%h want=F000", menu_display); end
    total++; if ({FSM_outputs, bin_bcd_select} !== 4'b0101) begin bad++; $display("FAIL br_no_early_commit got=%b want=0101", {FSM_outputs, bin_bcd_select}); end
    mixed = 1'b0;
    drive(B_ENTER);
    repeat (12) begin
      step(1);
      if (!(({FSM_outputs, bin_bcd_select} === 4'b0101) || ({FSM_outputs, bin_bcd_select} === 4'b1100)))
        mixed = 1'b1;
    end
    drive(B_NONE);
    step(8);
    total++; if (mixed !== 1'b0) begin bad++; $display("FAIL br_atomic got=%b want=0", mixed); end
    total++; if (FSM_outputs !== 2'b11) begin bad++; $display("FAIL br_src_commit got=%b want=11", FSM_outputs); end
    total++; if (bin_bcd_select !== 2'b00) begin bad++; $display("FAIL br_fmt_commit got=%b want=00", bin_bcd_select); end
    total++; if (menu_display !== 16'h0000) begin bad++; $display("FAIL br_disp_run got=%h want=0000", menu_display); end
    total++; if (menu_active !== 1'b0) begin bad++; $display("FAIL br_active_run got=%b want=0", menu_active); end
  endtask

  task automatic test_debounce;
    do_reset();
    drive(B_ENTER);
    step(3);
    drive(B_NONE);
    step(4);
    repeat (4) begin
      drive(B_ENTER);
      step(2);
      drive(B_NONE);
      step(2);
    end
    step(10);
    total++; if (menu_active !== 1'b0) begin bad++; $display("FAIL db_glitch got=%b want=0", menu_active); end
    total++; if (menu_display !== 16'h0000) begin bad++; $display("FAIL db_glitch_disp got=%h want=0000", menu_display); end
    drive(B_ENTER);
    step(8);
    total++; if (menu_active !== 1'b0) begin bad++; $display("FAIL db_early got=%b want=0", menu_active); end
    step(1);
    total++; if (menu_active !== 1'b1) begin bad++; $display("FAIL db_latency got=%b want=1", menu_active); end
    total++; if (menu_display !== 16'h5001) begin bad++; $display("FAIL db_disp got=%h want=5001", menu_display); end
    drive(B_NONE);
    step(8);
  endtask

  task automatic test_wrap;
    do_reset();
    press(B_ENTER);
    press(B_PREV);
    total++; if (menu_display !== 16'h5000) begin bad++; $display("FAIL wr_src0 got=%h want=5000", menu_display); end
    press(B_PREV);
    total++; if (menu_display !== 16'h5003) begin bad++; $display("FAIL wr_src3 got=%h want=5003", menu_display); end
    press(B_ENTER);
    press(B_PREV);
    total++; if (menu_display !== 16'hF000) begin bad++; $display("FAIL wr_fmt0 got=%h want=F000", menu_display); end
    press(B_PREV);
    total++; if (menu_display !== 16'hF002) begin bad++; $display("FAIL wr_fmt_prev got=%h want=F002", menu_display); end
    press(B_NEXT);
    total++; if (menu_display !== 16'hF000) begin bad++; $display("FAIL wr_fmt_next got=%h want=F000", menu_display); end
    press(B_NEXT);
    total++; if (menu_display !== 16'hF001) begin bad++; $display("FAIL wr_fmt1 got=%h want=F001", menu_display); end
  endtask

  task automatic test_timeout;
    int n;
    do_reset();
    press(B_ENTER);
    press(B_NEXT);
    total++; if (menu_display !== 16'h5002) begin bad++; $display("FAIL to_cand got=%h want=5002", menu_display); end
    step(30);
    total++; if (menu_active !== 1'b1) begin bad++; $display("FAIL to_premature got=%b want=1", menu_active); end
    n = 0;
    while (menu_active === 1'b1 && n < 60) begin
      step(1);
      n++;
    end
    total++; if (menu_active !== 1'b0) begin bad++; $display("FAIL to_expire got=%b want=0", menu_active); end
    total++; if ({FSM_outputs, bin_bcd_select} !== 4'b0101) begin bad++; $display("FAIL to_outputs got=%b want=0101", {FSM_outputs, bin_bcd_select}); end
  endtask

  task automatic test_arbitration;
    do_reset();
    press(B_ENTER);
    press(B_ENTER | B_NEXT);
    total++; if (menu_display !== 16'hF001) begin bad++; $display("FAIL arb_enter_wins got=%h want=F001", menu_display); end
    press(B_NEXT | B_PREV);
    total++; if (menu_display !== 16'hF001) begin bad++; $display("FAIL arb_next_prev got=%h want=F001", menu_display); end
    press(B_ENTER);
    total++; if ({FSM_outputs, bin_bcd_select} !== 4'b0101) begin bad++; $display("FAIL arb_commit got=%b want=0101", {FSM_outputs, bin_bcd_select}); end
    total++; if (menu_active !== 1'b0) begin bad++; $display("FAIL arb_run got=%b want=0", menu_active); end
  endtask

  task automatic test_reset_mid_menu;
    do_reset();
    press(B_ENTER);
    press(B_NEXT);
    press(B_ENTER);
    press(B_NEXT);
    total++; if (menu_display !== 16'hF002) begin bad++; $display("FAIL rm_browse got=%h want=F002", menu_display); end
    reset = 1'b1;
    step(1);
    total++; if ({FSM_outputs, bin_bcd_select} !== 4'b0101) begin bad++; $display("FAIL rm_outputs got=%b want=0101", {FSM_outputs, bin_bcd_select}); end
    total++; if (menu_active !== 1'b0) begin bad++; $display("FAIL rm_active got=%b want=0", menu_active); end
    total++; if (menu_display !== 16'h0000) begin bad++; $display("FAIL rm_disp got=%h want=0000", menu_display); end
    reset = 1'b0;
    step(5);
    total++; if ({FSM_outputs, bin_bcd_select, menu_active} !== 5'b01010) begin bad++; $display("FAIL rm_after got=%b want=01010", {FSM_outputs, bin_bcd_select, menu_active}); end
  endtask

  initial begin
    test_reset();
    test_browse_commit();
    test_debounce();
    test_wrap();
    test_timeout();
    test_arbitration();
    test_reset_mid_menu();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
